// File: rtl/clk_switch_ble_pkg.sv
// Shared definitions for the BLE PHY clock-switch sequencer: state encoding,
// constant-width helpers and the one-hot select encoder.
package clk_switch_ble_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GATE_OFF = 2'd1;
  localparam logic [1:0] ST_SELECT   = 2'd2;
  localparam logic [1:0] ST_ACK      = 2'd3;

  localparam int MAX_CLOCKS = 32;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    GATE_OFF = ST_GATE_OFF,
    SELECT   = ST_SELECT,
    ACK      = ST_ACK
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Out-of-range indices encode to all-zero so they can never enable a mux leg.
  function automatic logic [MAX_CLOCKS-1:0] onehot(input int unsigned idx);
    return (idx < MAX_CLOCKS) ? (MAX_CLOCKS'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/clk_switch_ctrl_ble_if.sv
// Requester/mux-facing signal bundle of the clock-switch sequencer.
interface clk_switch_ctrl_ble_if #(
  parameter int NUM_CLOCKS = 2,
  parameter int NUM_REQ    = 3,
  parameter int SRC_W      = 1
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*SRC_W-1:0] req_src;
  logic [NUM_REQ-1:0]       done;
  logic                     err;
  logic [NUM_CLOCKS-1:0]    clk_select;
  logic [SRC_W-1:0]         cur_src;
  logic                     busy;

  modport master (
    output req_valid, req_src,
    input  done, err, clk_select, cur_src, busy
  );

  modport slave (
    input  req_valid, req_src,
    output done, err, clk_select, cur_src, busy
  );
endinterface

// File: rtl/rr_arbiter_ble.sv
// Round-robin arbiter: combinational grant from a registered priority pointer
// that moves past the winner whenever a grant is taken.
module rr_arbiter_ble
  import clk_switch_ble_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_q;

  always_comb begin
    logic        found;
    int unsigned idx;
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && |req) begin
      ptr_q <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/clk_switch_ctrl_ble.sv
// Break-before-make sequencer for the BLE PHY clock mux: arbitrates source
// requests, gates all selects off, drains, selects the new leg, settles, acks.
module clk_switch_ctrl_ble
  import clk_switch_ble_pkg::*;
#(
  parameter int NUM_CLOCKS    = 2,
  parameter int NUM_REQ       = 3,
  parameter int SRC_W         = 1,
  parameter int DRAIN_CYCLES  = 8,
  parameter int SETTLE_CYCLES = 8,
  parameter int DEFAULT_SRC   = 0
) (
  input logic                  clk,
  input logic                  rst,
  clk_switch_ctrl_ble_if.slave bus
);

  localparam int CNT_MAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;

  localparam logic [CNT_W-1:0]      DRAIN_LD    = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SETTLE_LD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [NUM_CLOCKS-1:0] DEFAULT_SEL = NUM_CLOCKS'(onehot(DEFAULT_SRC));
  localparam logic [SRC_W-1:0]      DEFAULT_IDX = SRC_W'(DEFAULT_SRC);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [SRC_W-1:0]      tgt_q;
  logic [NUM_REQ-1:0]    grant_q;
  logic                  inval_q;
  logic [NUM_CLOCKS-1:0] sel_q;
  logic [SRC_W-1:0]      cur_q;
  logic [NUM_REQ-1:0]    done_q;
  logic                  err_q;
  logic                  busy_q;

  logic [NUM_REQ-1:0]    arb_oh;
  logic [IDX_W-1:0]      arb_idx;
  logic [SRC_W-1:0]      tgt_d;
  logic                  inval_d;
  logic [NUM_CLOCKS-1:0] tgt_oh;
  logic                  ack_now;

  rr_arbiter_ble #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .advance   (state_q == IDLE),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx)
  );

  // ACK is entered either with done already issued (from SELECT) or without it
  // (same-source / invalid path), in which case done goes out one cycle later.
  always_comb begin
    tgt_d   = bus.req_src[int'(arb_idx)*SRC_W +: SRC_W];
    inval_d = int'(tgt_d) >= NUM_CLOCKS;
    tgt_oh  = NUM_CLOCKS'(onehot(int'(tgt_q)));
    ack_now = ((state_q == SELECT) && (cnt_q == '0)) ||
              ((state_q == ACK) && !(|done_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= DEFAULT_SEL;
      cur_q   <= DEFAULT_IDX;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|bus.req_valid) begin
            busy_q  <= 1'b1;
            tgt_q   <= tgt_d;
            grant_q <= arb_oh;
            inval_q <= inval_d;
            if (inval_d || (tgt_d == cur_q)) begin
              state_q <= ACK;
            end else begin
              state_q <= GATE_OFF;
              sel_q   <= '0;
              cnt_q   <= DRAIN_LD;
            end
          end
        end
        GATE_OFF: begin
          if (cnt_q == '0) begin
            state_q <= SELECT;
            sel_q   <= tgt_oh;
            cnt_q   <= SETTLE_LD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SELECT: begin
          if (cnt_q == '0) state_q <= ACK;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ACK: begin
          if (|done_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (ack_now) begin
        done_q <= grant_q;
        err_q  <= inval_q;
        if (!inval_q) cur_q <= tgt_q;
      end
    end
  end

  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.clk_select = sel_q;
  assign bus.cur_src    = cur_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_clk_switch_ctrl_ble.sv
// Bench for clk_switch_ctrl_ble: directed vector table, reset/round-robin
// sequences, then random requests against a timeline reference model.
module tb_clk_switch_ctrl_ble;

  localparam int NC = 2;
  localparam int NR = 3;
  localparam int SW = 2;
  localparam int DC = 8;
  localparam int SC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clk_switch_ctrl_ble_if #(.NUM_CLOCKS(NC), .NUM_REQ(NR), .SRC_W(SW)) bus ();

  clk_switch_ctrl_ble #(
    .NUM_CLOCKS(NC), .NUM_REQ(NR), .SRC_W(SW),
    .DRAIN_CYCLES(DC), .SETTLE_CYCLES(SC), .DEFAULT_SRC(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [SW-1:0] s);
    bus.req_valid[i]        = v;
    bus.req_src[i*SW +: SW] = s;
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.req_valid = '0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reference model: a transaction timeline (grant time, done time, select time)
  logic [NC-1:0] m_sel;
  logic [SW-1:0] m_cur;
  logic [SW-1:0] m_tgt;
  logic [NR-1:0] m_done;
  logic          m_err, m_busy, m_fly, m_sw, m_inv;
  int            m_ptr, m_g, m_grant_t, m_done_t;

  task automatic model_reset();
    m_sel = NC'(1); m_cur = '0; m_tgt = '0; m_done = '0; m_err = 1'b0;
    m_busy = 1'b0; m_fly = 1'b0; m_sw = 1'b0; m_inv = 1'b0;
    m_ptr = 0; m_g = 0; m_grant_t = -100; m_done_t = -100;
  endtask

  task automatic model_step(input int t, input logic [NR-1:0] rv, input logic [NR*SW-1:0] rs);
    logic was_fly;
    int   win;
    was_fly = m_fly;
    m_done  = '0;
    m_err   = 1'b0;
    if (m_fly && t == m_done_t) begin
      m_done[m_g] = 1'b1;
      m_err       = m_inv;
      if (!m_inv) m_cur = m_tgt;
    end
    if (m_fly && t == m_done_t + 1) begin
      m_fly  = 1'b0;
      m_busy = 1'b0;
    end
    if (m_fly && m_sw && t == m_grant_t + DC) m_sel = NC'(1) << m_tgt;
    if (!was_fly && rv != '0) begin
      win = -1;
      for (int k = 0; k < NR; k++)
        if (win < 0 && rv[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
      m_g       = win;
      m_ptr     = (win + 1) % NR;
      m_tgt     = rs[win*SW +: SW];
      m_inv     = int'(m_tgt) >= NC;
      m_sw      = !m_inv && (m_tgt != m_cur);
      m_fly     = 1'b1;
      m_busy    = 1'b1;
      m_grant_t = t;
      m_done_t  = m_sw ? t + DC + SC : t + 1;
      if (m_sw) m_sel = '0;
    end
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic [SW-1:0] src;
    int            drop_at;
    int            done_off;
    int            err_n;
    logic [NC-1:0] sel_k0;
    logic [NC-1:0] sel_k8;
    logic [NC-1:0] sel_end;
    logic [SW-1:0] cur_end;
    int            busy_n;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int idx, got_off, err_n, busy_n, multi, bad_sel, nd, total;
    logic [NR-1:0] got_done;
    logic [NC-1:0] s0, s8;
    int ord[4];
    int offs[4];
    logic [NR-1:0] rv;
    logic [NR*SW-1:0] rs;

    vecs[0] = '{3'b001, 2'd1, -1, 16, 0, 2'b00, 2'b10, 2'b10, 2'd1, 17};
    vecs[1] = '{3'b010, 2'd1, -1,  1, 0, 2'b10, 2'b10, 2'b10, 2'd1,  2};
    vecs[2] = '{3'b100, 2'd3, -1,  1, 1, 2'b10, 2'b10, 2'b10, 2'd1,  2};
    vecs[3] = '{3'b001, 2'd0,  3, 16, 0, 2'b00, 2'b01, 2'b01, 2'd0, 17};
    vecs[4] = '{3'b010, 2'd2, -1,  1, 1, 2'b01, 2'b01, 2'b01, 2'd0,  2};
    vecs[5] = '{3'b100, 2'd1, -1, 16, 0, 2'b00, 2'b10, 2'b10, 2'd1, 17};

    bus.req_valid = '0;
    bus.req_src   = '0;

    apply_reset(2);
    @(negedge clk);
    chk("reset_sel", 32'(bus.clk_select), 32'h1);
    chk("reset_cur", 32'(bus.cur_src), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    chk("reset_err", 32'(bus.err), 32'h0);

    for (int r = 0; r < 6; r++) begin
      @(posedge clk);
      #1;
      idx = 0;
      for (int i = 0; i < NR; i++) if (vecs[r].valid[i]) idx = i;
      set_req(idx, 1'b1, vecs[r].src);
      @(posedge clk);
      got_off = -1; got_done = '0; err_n = 0; busy_n = 0; multi = 0; bad_sel = 0;
      s0 = '0; s8 = '0;
      for (int k = 0; k < 24; k++) begin
        @(negedge clk);
        if (k == 0) s0 = bus.clk_select;
        if (k == DC) s8 = bus.clk_select;
        if (bus.busy) busy_n++;
        if (bus.err) err_n++;
        if ($countones(bus.clk_select) > 1) bad_sel++;
        if (|bus.done) begin
          if (got_off < 0) begin
            got_off  = k;
            got_done = bus.done;
          end else multi++;
          bus.req_valid[idx] = 1'b0;
        end
        if (k == vecs[r].drop_at) bus.req_valid[idx] = 1'b0;
      end
      chk($sformatf("vec%0d_done_off", r), 32'(got_off), 32'(vecs[r].done_off));
      chk($sformatf("vec%0d_done_vec", r), 32'(got_done), 32'(vecs[r].valid));
      chk($sformatf("vec%0d_err", r), 32'(err_n), 32'(vecs[r].err_n));
      chk($sformatf("vec%0d_sel_e0", r), 32'(s0), 32'(vecs[r].sel_k0));
      chk($sformatf("vec%0d_sel_e8", r), 32'(s8), 32'(vecs[r].sel_k8));
      chk($sformatf("vec%0d_sel_end", r), 32'(bus.clk_select), 32'(vecs[r].sel_end));
      chk($sformatf("vec%0d_cur_end", r), 32'(bus.cur_src), 32'(vecs[r].cur_end));
      chk($sformatf("vec%0d_busy_cyc", r), 32'(busy_n), 32'(vecs[r].busy_n));
      chk($sformatf("vec%0d_extra_done", r), 32'(multi), 32'h0);
      chk($sformatf("vec%0d_multi_sel", r), 32'(bad_sel), 32'h0);
    end

    // Reset in the middle of the gate-off drain
    @(posedge clk);
    #1 set_req(0, 1'b1, 2'd0);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    bus.req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_sel", 32'(bus.clk_select), 32'h1);
    chk("midrst_cur", 32'(bus.cur_src), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_done", 32'(bus.done), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    nd = 0; busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (|bus.done) nd++;
      if (bus.busy) busy_n++;
    end
    chk("midrst_no_done", 32'(nd), 32'h0);
    chk("midrst_idle", 32'(busy_n), 32'h0);
    chk("midrst_sel_hold", 32'(bus.clk_select), 32'h1);

    // Round-robin with all requesters held, requester 0 re-raised after service
    apply_reset(2);
    @(posedge clk);
    #1;
    set_req(0, 1'b1, 2'd1);
    set_req(1, 1'b1, 2'd0);
    set_req(2, 1'b1, 2'd1);
    @(posedge clk);
    nd = 0; total = 0; multi = 0;
    for (int i = 0; i < 4; i++) begin ord[i] = -1; offs[i] = -1; end
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (|bus.done) begin
        total++;
        if ($countones(bus.done) != 1) multi++;
        for (int i = 0; i < NR; i++) begin
          if (bus.done[i]) begin
            if (nd < 4) begin ord[nd] = i; offs[nd] = k; end
            nd++;
            bus.req_valid[i] = 1'b0;
          end
        end
        if (nd == 1) set_req(0, 1'b1, 2'd1);
      end
    end
    chk("rr_order0", 32'(ord[0]), 32'd0);
    chk("rr_order1", 32'(ord[1]), 32'd1);
    chk("rr_order2", 32'(ord[2]), 32'd2);
    chk("rr_order3", 32'(ord[3]), 32'd0);
    chk("rr_done_t0", 32'(offs[0]), 32'd16);
    chk("rr_done_t1", 32'(offs[1]), 32'd34);
    chk("rr_done_t2", 32'(offs[2]), 32'd52);
    chk("rr_done_t3", 32'(offs[3]), 32'd55);
    chk("rr_done_cycles", 32'(total), 32'd4);
    chk("rr_onehot", 32'(multi), 32'd0);

    // Random requests against the reference model
    apply_reset(1);
    model_reset();
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk);
      rv = bus.req_valid;
      rs = bus.req_src;
      model_step(c, rv, rs);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (bus.req_valid[i]) begin
          if (m_done[i]) begin
            if ($urandom_range(3) != 0) bus.req_valid[i] = 1'b0;
          end else if ($urandom_range(99) == 0) begin
            bus.req_valid[i] = 1'b0;
          end
        end else if ($urandom_range(9) == 0) begin
          if ($urandom_range(7) == 0) set_req(i, 1'b1, SW'(2 + $urandom_range(1)));
          else                        set_req(i, 1'b1, SW'($urandom_range(1)));
        end
      end
      @(negedge clk);
      chk("rnd_done", 32'(bus.done), 32'(m_done));
      chk("rnd_err", 32'(bus.err), 32'(m_err));
      chk("rnd_sel", 32'(bus.clk_select), 32'(m_sel));
      chk("rnd_cur", 32'(bus.cur_src), 32'(m_cur));
      chk("rnd_busy", 32'(bus.busy), 32'(m_busy));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
